// File: rtl/gray_counter_n_pkg.sv
// Shared Gray-code helpers and direction encodings for the Gray counter family.
package gray_pkg;

    // Count direction encodings for the Dir input.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Widest counter the helper functions cover; narrower callers zero-extend.
    localparam int unsigned GRAY_MAX_W = 64;

    // Binary to reflected Gray code.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reflected Gray code to binary; leading zeros of a narrow value decode to zeros.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = int'(GRAY_MAX_W) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_counter_n_gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits at or above it. Shared with the receiver-side synchroniser.
module gray2bin_n #(
    parameter int unsigned WIDTH = 3
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin_c
);

    // Prefix XOR from the MSB down, one reduction per output bit.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        assign o_bin_c[i] = ^i_gray[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_counter_n.sv
// N-bit Gray-code counter: up/down, parallel load, wrap or saturate at the
// ends, sticky overflow/underflow and a one-cycle end-event pulse.
module gray_counter_n
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH    = 3,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Dir,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             ClrFlags,
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] BinOut,
    output logic             Overflow,
    output logic             Underflow,
    output logic             Wrap
);

    localparam logic [WIDTH-1:0] MAX_BIN = '1;

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_ovf;
    logic             r_udf;
    logic             r_wrap;

    logic [WIDTH-1:0] w_load_bin;
    logic [WIDTH-1:0] w_bin_nxt;
    logic [WIDTH-1:0] w_gray_nxt;
    logic             w_ovf_set;
    logic             w_udf_set;
    logic             w_wrap_nxt;
    logic             w_at_top;
    logic             w_at_bot;

    gray2bin_n #(
        .WIDTH (WIDTH)
    ) u_load_dec (
        .i_gray  (LoadVal),
        .o_bin_c (w_load_bin)
    );

    // End detection works on the binary state, never on the Gray code.
    assign w_at_top = (r_bin == MAX_BIN);
    assign w_at_bot = (r_bin == '0);

    // Next binary state and end events; Load wins over En.
    always_comb begin
        w_bin_nxt  = r_bin;
        w_ovf_set  = 1'b0;
        w_udf_set  = 1'b0;
        w_wrap_nxt = 1'b0;
        if (Load) begin
            w_bin_nxt = w_load_bin;
        end else if (En) begin
            if (Dir == DIR_UP) begin
                if (w_at_top) begin
                    w_ovf_set  = 1'b1;
                    w_wrap_nxt = 1'b1;
                    w_bin_nxt  = SATURATE ? r_bin : '0;
                end else begin
                    w_bin_nxt = r_bin + WIDTH'(1);
                end
            end else if (Dir == DIR_DOWN) begin
                if (w_at_bot) begin
                    w_udf_set  = 1'b1;
                    w_wrap_nxt = 1'b1;
                    w_bin_nxt  = SATURATE ? r_bin : MAX_BIN;
                end else begin
                    w_bin_nxt = r_bin - WIDTH'(1);
                end
            end
        end
    end

    // Gray encode in front of the output register so Output and BinOut move together.
    assign w_gray_nxt = WIDTH'(bin2gray(GRAY_MAX_W'(w_bin_nxt)));

    // State, flags and pulse register; synchronous reset overrides everything.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_bin  <= '0;
            r_gray <= '0;
            r_ovf  <= 1'b0;
            r_udf  <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_bin_nxt;
            r_gray <= w_gray_nxt;
            r_ovf  <= (r_ovf & ~ClrFlags) | w_ovf_set;
            r_udf  <= (r_udf & ~ClrFlags) | w_udf_set;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign Output    = r_gray;
    assign BinOut    = r_bin;
    assign Overflow  = r_ovf;
    assign Underflow = r_udf;
    assign Wrap      = r_wrap;

endmodule

// File: tb/tb_gray_counter_n.sv
// Bench for gray_counter_n: three instances (3-bit wrap, 3-bit saturate,
// 8-bit wrap) share one stimulus stream; a reference model pushes expected
// outputs to a scoreboard queue at drive time, popped after the clock edge.
module tb_gray_counter_n;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       dir;
    logic       load;
    logic       clr;
    logic [7:0] load_val;

    logic [2:0] gray0, bin0, gray1, bin1;
    logic [7:0] gray2, bin2;
    logic       ovf0, udf0, wrap0;
    logic       ovf1, udf1, wrap1;
    logic       ovf2, udf2, wrap2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gray_counter_n #(.WIDTH(3), .SATURATE(1'b0)) u_dut_wrap (
        .Clk(clk), .Reset(rst_n), .En(en), .Dir(dir), .Load(load),
        .LoadVal(load_val[2:0]), .ClrFlags(clr), .Output(gray0), .BinOut(bin0),
        .Overflow(ovf0), .Underflow(udf0), .Wrap(wrap0)
    );

    gray_counter_n #(.WIDTH(3), .SATURATE(1'b1)) u_dut_sat (
        .Clk(clk), .Reset(rst_n), .En(en), .Dir(dir), .Load(load),
        .LoadVal(load_val[2:0]), .ClrFlags(clr), .Output(gray1), .BinOut(bin1),
        .Overflow(ovf1), .Underflow(udf1), .Wrap(wrap1)
    );

    gray_counter_n #(.WIDTH(8), .SATURATE(1'b0)) u_dut_w8 (
        .Clk(clk), .Reset(rst_n), .En(en), .Dir(dir), .Load(load),
        .LoadVal(load_val), .ClrFlags(clr), .Output(gray2), .BinOut(bin2),
        .Overflow(ovf2), .Underflow(udf2), .Wrap(wrap2)
    );

    typedef struct packed {
        logic [7:0] gray;
        logic [7:0] bin;
        logic       ovf;
        logic       udf;
        logic       wrap;
    } obs_t;

    typedef obs_t [2:0] snap_t;

    snap_t sb_q[$];

    // Reference model state per instance.
    logic [7:0]  m_bin  [3];
    bit          m_ovf  [3];
    bit          m_udf  [3];
    bit          m_wrap [3];
    int unsigned m_w    [3] = '{3, 3, 8};
    bit          m_sat  [3] = '{1'b0, 1'b1, 1'b0};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_g2b(input logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Advance the model for every instance and queue the expected outputs.
    task automatic model_step(input bit r, input bit e, input bit d, input bit l,
                              input logic [7:0] lv, input bit c);
        snap_t      s;
        logic [7:0] mx;
        logic [7:0] nb;
        bit         so, su, wr;
        for (int k = 0; k < 3; k++) begin
            mx = 8'((32'd1 << m_w[k]) - 32'd1);
            nb = m_bin[k];
            so = 1'b0;
            su = 1'b0;
            wr = 1'b0;
            if (!r) begin
                m_bin[k]  = 8'd0;
                m_ovf[k]  = 1'b0;
                m_udf[k]  = 1'b0;
                m_wrap[k] = 1'b0;
            end else begin
                if (l) begin
                    nb = m_g2b(lv & mx);
                end else if (e) begin
                    if (d) begin
                        if (m_bin[k] == mx) begin
                            so = 1'b1; wr = 1'b1;
                            nb = m_sat[k] ? m_bin[k] : 8'd0;
                        end else begin
                            nb = (m_bin[k] + 8'd1) & mx;
                        end
                    end else begin
                        if (m_bin[k] == 8'd0) begin
                            su = 1'b1; wr = 1'b1;
                            nb = m_sat[k] ? m_bin[k] : mx;
                        end else begin
                            nb = m_bin[k] - 8'd1;
                        end
                    end
                end
                m_ovf[k]  = (c ? 1'b0 : m_ovf[k]) | so;
                m_udf[k]  = (c ? 1'b0 : m_udf[k]) | su;
                m_wrap[k] = wr;
                m_bin[k]  = nb;
            end
            s[k].gray = m_bin[k] ^ (m_bin[k] >> 1);
            s[k].bin  = m_bin[k];
            s[k].ovf  = m_ovf[k];
            s[k].udf  = m_udf[k];
            s[k].wrap = m_wrap[k];
        end
        sb_q.push_back(s);
    endtask

    // Pop one scoreboard entry and compare every instance against it.
    task automatic compare_all();
        snap_t s;
        obs_t  o [3];
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 32'd1, 32'd0);
            return;
        end
        s = sb_q.pop_front();
        o[0] = '{gray: 8'(gray0), bin: 8'(bin0), ovf: ovf0, udf: udf0, wrap: wrap0};
        o[1] = '{gray: 8'(gray1), bin: 8'(bin1), ovf: ovf1, udf: udf1, wrap: wrap1};
        o[2] = '{gray: gray2, bin: bin2, ovf: ovf2, udf: udf2, wrap: wrap2};
        for (int k = 0; k < 3; k++) begin
            check_val($sformatf("sb%0d_gray", k), 32'(o[k].gray), 32'(s[k].gray));
            check_val($sformatf("sb%0d_bin",  k), 32'(o[k].bin),  32'(s[k].bin));
            check_val($sformatf("sb%0d_ovf",  k), 32'(o[k].ovf),  32'(s[k].ovf));
            check_val($sformatf("sb%0d_udf",  k), 32'(o[k].udf),  32'(s[k].udf));
            check_val($sformatf("sb%0d_wrap", k), 32'(o[k].wrap), 32'(s[k].wrap));
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then check just after the rising edge.
    task automatic drive(input bit r, input bit e, input bit d, input bit l,
                         input logic [7:0] lv, input bit c);
        @(negedge clk);
        rst_n    = r;
        en       = e;
        dir      = d;
        load     = l;
        load_val = lv;
        clr      = c;
        model_step(r, e, d, l, lv, c);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] gseq [8];
        logic [7:0] prev;
        bit         d;
        gseq = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};

        rst_n = 1'b0; en = 1'b0; dir = 1'b0; load = 1'b0; load_val = 8'd0; clr = 1'b0;

        // Reset, then a full up cycle of the 3-bit counter.
        drive(0, 0, 0, 0, 8'h00, 0);
        drive(0, 0, 0, 0, 8'h00, 0);
        check_val("rst_gray", 32'(gray0), 32'd0);
        check_val("rst_flags", 32'({ovf0, udf0, wrap0}), 32'd0);
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 1, 0, 8'h00, 0);
            check_val($sformatf("up_seq%0d", i), 32'(gray0), 32'(gseq[i]));
            check_val($sformatf("up_wrap%0d", i), 32'(wrap0), (i == 7) ? 32'd1 : 32'd0);
        end
        check_val("up_ovf", 32'(ovf0), 32'd1);

        // Clear flags, then underflow from zero and one more down step.
        drive(1, 0, 0, 0, 8'h00, 1);
        check_val("clr_ovf", 32'(ovf0), 32'd0);
        drive(1, 1, 0, 0, 8'h00, 0);
        check_val("dn_gray", 32'(gray0), 32'b100);
        check_val("dn_bin", 32'(bin0), 32'd7);
        check_val("dn_udf", 32'(udf0), 32'd1);
        check_val("dn_wrap", 32'(wrap0), 32'd1);
        drive(1, 1, 0, 0, 8'h00, 0);
        check_val("dn2_gray", 32'(gray0), 32'b101);
        check_val("dn2_wrap", 32'(wrap0), 32'd0);

        // Saturating instance pinned at the top for three cycles.
        drive(0, 0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 7; i++) drive(1, 1, 1, 0, 8'h00, 0);
        check_val("sat_top", 32'(gray1), 32'b100);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 0, 8'h00, 0);
            check_val($sformatf("sat_hold%0d", i), 32'(gray1), 32'b100);
            check_val($sformatf("sat_wrap%0d", i), 32'(wrap1), 32'd1);
        end
        check_val("sat_ovf", 32'(ovf1), 32'd1);

        // Load beats count in the same cycle.
        drive(1, 1, 1, 1, 8'h06, 0);
        check_val("ld_gray", 32'(gray0), 32'b110);
        check_val("ld_bin", 32'(bin0), 32'd4);
        drive(1, 1, 1, 0, 8'h00, 0);
        check_val("ld_next", 32'(gray0), 32'b111);

        // Set wins over a simultaneous clear; clear alone then drops the flag.
        drive(1, 0, 0, 0, 8'h00, 1);
        drive(1, 0, 0, 1, 8'h04, 0);
        drive(1, 1, 1, 0, 8'h00, 0);
        check_val("ovf_set", 32'(ovf0), 32'd1);
        drive(1, 0, 0, 1, 8'h04, 0);
        drive(1, 1, 1, 0, 8'h00, 1);
        check_val("ovf_setclr", 32'(ovf0), 32'd1);
        check_val("ovf_setclr_wrap", 32'(wrap0), 32'd1);
        drive(1, 0, 0, 0, 8'h00, 1);
        check_val("ovf_clr", 32'(ovf0), 32'd0);
        check_val("ovf_clr_wrap", 32'(wrap0), 32'd0);

        // Reset mid-count together with a load.
        drive(0, 0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) drive(1, 1, 1, 0, 8'h00, 0);
        check_val("mid_gray", 32'(gray0), 32'b010);
        drive(0, 1, 1, 1, 8'h05, 0);
        check_val("mid_rst_gray", 32'(gray0), 32'd0);
        check_val("mid_rst_bin", 32'(bin0), 32'd0);
        check_val("mid_rst_w8", 32'({gray2, bin2}), 32'd0);

        // Random up/down walk on the 8-bit counter: one Output bit per step.
        prev = gray2;
        for (int i = 0; i < 300; i++) begin
            d = 1'($urandom_range(0, 1));
            drive(1, 1, d, 0, 8'h00, 0);
            check_val($sformatf("walk_bits%0d", i), 32'($countones(gray2 ^ prev)), 32'd1);
            prev = gray2;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
